// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 4-input gate through all 16 vectors, samples its
// output after a programmable settle time and compares it with a golden table.
module truth_table_sweeper #(
  parameter logic [15:0] EXPECTED = 16'hE605,
  parameter int unsigned SETTLE   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [3:0]  o_drive,
  input  logic        i_dut_out,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_captured,
  output logic [4:0]  o_mismatch_cnt,
  output logic [3:0]  o_first_fail,
  output logic        o_fail_valid
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_j;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_drive;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_captured;
  logic [4:0]       r_mismatch_cnt;
  logic [3:0]       r_first_fail;
  logic             r_fail_valid;

  logic             w_sample;
  logic             w_last_vec;
  logic [3:0]       w_bit_idx;
  logic             w_miss;
  logic [4:0]       w_mis_next;

  // Sample strobe (abort suppresses it) and mismatch of the current vector
  assign w_sample   = (r_state == S_HOLD) && !i_abort && (r_cnt == LAST_CNT);
  assign w_last_vec = (r_j == 4'd15);
  assign w_bit_idx  = ~r_j;
  assign w_miss     = i_dut_out ^ EXPECTED[w_bit_idx];
  assign w_mis_next = r_mismatch_cnt + 5'(w_miss);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_HOLD;
      S_HOLD: begin
        if (i_abort)                     w_next = S_IDLE;
        else if (w_sample && w_last_vec) w_next = S_FINISH;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Sweep datapath and registered result outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_j            <= '0;
      r_cnt          <= '0;
      r_drive        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_captured     <= '0;
      r_mismatch_cnt <= '0;
      r_first_fail   <= '0;
      r_fail_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_drive <= '0;
          if (i_start) begin
            r_j            <= '0;
            r_cnt          <= '0;
            r_busy         <= 1'b1;
            r_pass         <= 1'b0;
            r_captured     <= '0;
            r_mismatch_cnt <= '0;
            r_first_fail   <= '0;
            r_fail_valid   <= 1'b0;
          end
        end
        S_HOLD: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_drive <= '0;
          end else if (w_sample) begin
            r_captured[w_bit_idx] <= i_dut_out;
            r_mismatch_cnt        <= w_mis_next;
            r_cnt                 <= '0;
            if (w_miss && !r_fail_valid) begin
              r_first_fail <= r_j;
              r_fail_valid <= 1'b1;
            end
            if (w_last_vec) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_pass  <= (w_mis_next == 5'd0);
              r_drive <= '0;
            end else begin
              r_j     <= r_j + 4'd1;
              r_drive <= r_j + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_drive <= '0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_drive        = r_drive;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_pass         = r_pass;
  assign o_captured     = r_captured;
  assign o_mismatch_cnt = r_mismatch_cnt;
  assign o_first_fail   = r_first_fail;
  assign o_fail_valid   = r_fail_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (SETTLE 2, 3, 1) driven by a
// behavioural gate model; completed sweeps are scored against a queue.
module tb_truth_table_sweeper;

  localparam logic [15:0] GOLD = 16'hE605;

  typedef struct {
    int          k;
    logic [15:0] cap;
    int          mis;
    int          first;
    logic        fv;
    logic        pass;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start      [3];
  logic        abort      [3];
  logic [3:0]  drive      [3];
  logic        dut_out    [3];
  logic        busy       [3];
  logic        done       [3];
  logic        pass       [3];
  logic [15:0] captured   [3];
  logic [4:0]  mismatch   [3];
  logic [3:0]  first_fail [3];
  logic        fail_valid [3];
  int          mode       [3];

  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned ST = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    truth_table_sweeper #(.EXPECTED(GOLD), .SETTLE(ST)) u_dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_start        (start[g]),
      .i_abort        (abort[g]),
      .o_drive        (drive[g]),
      .i_dut_out      (dut_out[g]),
      .o_busy         (busy[g]),
      .o_done         (done[g]),
      .o_pass         (pass[g]),
      .o_captured     (captured[g]),
      .o_mismatch_cnt (mismatch[g]),
      .o_first_fail   (first_fail[g]),
      .o_fail_valid   (fail_valid[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
  endfunction

  // mode 0: correct gate, 1: stuck-at-0, 2: stuck-at-1
  function automatic logic gate(input int m, input int j);
    logic [15:0] t;
    t = GOLD;
    if (m == 0) return t[15-j];
    if (m == 1) return 1'b0;
    return 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) dut_out[k] = gate(mode[k], int'(drive[k]));
  end

  // Expected results after the first n vectors have been sampled
  function automatic exp_t model(input int k, input int m, input int n);
    exp_t e;
    logic [15:0] t;
    logic b;
    t = GOLD;
    e.k = k; e.cap = '0; e.mis = 0; e.first = 0; e.fv = 1'b0;
    for (int j = 0; j < n; j++) begin
      b = gate(m, j);
      e.cap[15-j] = b;
      if (b != t[15-j]) begin
        e.mis++;
        if (!e.fv) begin
          e.first = j;
          e.fv    = 1'b1;
        end
      end
    end
    e.pass = (e.mis == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input int m);
    sb.push_back(model(k, m, 16));
  endtask

  task automatic start_pulse(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, "_drive"}, 32'(drive[k]), 0);
    check({tag, "_busy"}, 32'(busy[k]), 0);
    check({tag, "_done"}, 32'(done[k]), 0);
    check({tag, "_pass"}, 32'(pass[k]), 0);
    check({tag, "_cap"}, 32'(captured[k]), 0);
    check({tag, "_mis"}, 32'(mismatch[k]), 0);
    check({tag, "_ff"}, 32'(first_fail[k]), 0);
    check({tag, "_fv"}, 32'(fail_valid[k]), 0);
  endtask

  // Called in sweep cycle 1; follows drive each cycle until done, then scores
  task automatic wait_done(input int k, input bit repulse);
    int s;
    int c;
    exp_t e;
    s = settle_of(k);
    c = 1;
    while (!done[k] && c <= 16 * s + 4) begin
      if (c <= 16 * s) check("drive", 32'(drive[k]), 32'((c - 1) / s));
      check("busy", 32'(busy[k]), 1);
      if (repulse) start[k] = (c == 5 || c == 20);
      tick();
      c++;
    end
    if (repulse) start[k] = 1'b0;
    check("done_cycle", 32'(c), 32'(16 * s + 1));
    check("done", 32'(done[k]), 1);
    check("busy_at_done", 32'(busy[k]), 0);
    check("drive_at_done", 32'(drive[k]), 0);
    check("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_inst", 32'(k), 32'(e.k));
      check("captured", 32'(captured[k]), 32'(e.cap));
      check("mismatch", 32'(mismatch[k]), 32'(e.mis));
      check("first_fail", 32'(first_fail[k]), 32'(e.first));
      check("fail_valid", 32'(fail_valid[k]), 32'(e.fv));
      check("pass", 32'(pass[k]), 32'(e.pass));
    end
    tick();
    check("done_pulse_end", 32'(done[k]), 0);
    check("idle_busy", 32'(busy[k]), 0);
    if (sb.size() == 0 && e.k == k) check("pass_held", 32'(pass[k]), 32'(e.pass));
  endtask

  initial begin
    exp_t e;
    bit   seen_done;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      abort[k] = 1'b0;
      mode[k]  = 0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) check_zero(k, "reset");
    rst = 1'b0;
    tick();

    // Correct gate, SETTLE=2, with start re-pulsed mid-sweep
    mode[0] = 0;
    push_exp(0, 0);
    start_pulse(0);
    wait_done(0, 1'b1);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done[0] || busy[0]) seen_done = 1'b1;
      tick();
    end
    check("no_retrigger", 32'(seen_done), 0);

    // Stuck-at-0, SETTLE=2
    mode[0] = 1;
    push_exp(0, 1);
    start_pulse(0);
    wait_done(0, 1'b0);

    // Stuck-at-1, SETTLE=3
    mode[1] = 2;
    push_exp(1, 2);
    start_pulse(1);
    wait_done(1, 1'b0);

    // start held high, SETTLE=1: back-to-back sweeps
    mode[2] = 0;
    push_exp(2, 0);
    push_exp(2, 0);
    start[2] = 1'b1;
    tick();
    wait_done(2, 1'b0);
    tick();
    check("held_start_rebusy", 32'(busy[2]), 1);
    start[2] = 1'b0;
    wait_done(2, 1'b0);

    // Abort during j=6 with a stuck-at-0 gate
    mode[0] = 1;
    start_pulse(0);
    for (int i = 0; i < 12; i++) tick();
    check("pre_abort_drive", 32'(drive[0]), 6);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    e = model(0, 1, 6);
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_done", 32'(done[0]), 0);
    check("abort_drive", 32'(drive[0]), 0);
    check("abort_pass", 32'(pass[0]), 0);
    check("abort_cap", 32'(captured[0]), 32'(e.cap));
    check("abort_mis", 32'(mismatch[0]), 32'(e.mis));
    check("abort_ff", 32'(first_fail[0]), 32'(e.first));
    check("abort_fv", 32'(fail_valid[0]), 32'(e.fv));
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done[0] || busy[0]) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(seen_done), 0);

    // Reset during j=9, then a clean sweep
    mode[0] = 0;
    start_pulse(0);
    for (int i = 0; i < 18; i++) tick();
    check("pre_rst_drive", 32'(drive[0]), 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero(0, "midrst");
    tick();
    push_exp(0, 0);
    start_pulse(0);
    wait_done(0, 1'b0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
